// File: rtl/dispatch_if.sv
// Dispatch stage bus: IFQ head, issue-queue back-pressure, ROB
// events and the registered Dispatch_* strobes to the issue queues.
interface dispatch_if #(
  parameter int TAG_W = 5
);
  logic             ifq_valid;
  logic [31:0]      ifq_inst;
  logic             ifq_rd_en;
  logic             iq_int_full;
  logic             iq_mult_full;
  logic             iq_ldst_full;
  logic             rob_commit;
  logic             flush;
  logic             Dispatch_en_integer;
  logic             Dispatch_en_mult;
  logic             Dispatch_en_ld_st;
  logic [2:0]       Dispatch_opcode;
  logic             Dispatch_branch;
  logic [4:0]       Dispatch_shfamt;
  logic [15:0]      Dispatch_imm_ld_st;
  logic [4:0]       Dispatch_rs;
  logic [4:0]       Dispatch_rt;
  logic [4:0]       Dispatch_rd;
  logic [TAG_W-1:0] Dispatch_tag;
  logic             Dispatch_illegal;

  modport master (
    input  ifq_valid, ifq_inst,
    input  iq_int_full, iq_mult_full, iq_ldst_full,
    input  rob_commit, flush,
    output ifq_rd_en,
    output Dispatch_en_integer, Dispatch_en_mult,
    output Dispatch_en_ld_st, Dispatch_opcode,
    output Dispatch_branch, Dispatch_shfamt,
    output Dispatch_imm_ld_st, Dispatch_rs,
    output Dispatch_rt, Dispatch_rd,
    output Dispatch_tag, Dispatch_illegal
  );

  modport slave (
    output ifq_valid, ifq_inst,
    output iq_int_full, iq_mult_full, iq_ldst_full,
    output rob_commit, flush,
    input  ifq_rd_en,
    input  Dispatch_en_integer, Dispatch_en_mult,
    input  Dispatch_en_ld_st, Dispatch_opcode,
    input  Dispatch_branch, Dispatch_shfamt,
    input  Dispatch_imm_ld_st, Dispatch_rs,
    input  Dispatch_rt, Dispatch_rd,
    input  Dispatch_tag, Dispatch_illegal
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: pops the IFQ head, classifies it, allocates
// a ROB tag and strobes the matching issue queue one cycle later.
module dispatch_ctrl #(
  parameter int TAG_W     = 5,
  parameter int ROB_DEPTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  dispatch_if.master dif
);
  localparam int CNT_W = TAG_W + 1;

  typedef enum logic [1:0] {
    IDLE, DISPATCH, STALL, FLUSH
  } state_t;

  typedef enum logic [2:0] {
    C_INT, C_MULT, C_LDST, C_JMP, C_ILL
  } cls_t;

  state_t           state, nxt;
  cls_t             cls;
  logic [2:0]       alu;
  logic             br;
  logic [5:0]       op, fn;
  logic             tgt_full, rob_full, needs, blocked;
  logic             pop, go, com;
  logic [TAG_W-1:0] tag;
  logic [CNT_W-1:0] cnt;

  assign op = dif.ifq_inst[31:26];
  assign fn = dif.ifq_inst[5:0];

  always_comb begin
    cls = C_ILL;
    alu = 3'b000;
    br  = 1'b0;
    unique case (op)
      6'h00: begin
        cls = C_INT;
        case (fn)
          6'h18, 6'h19: cls = C_MULT;
          6'h22, 6'h23: alu = 3'b001;
          6'h24:        alu = 3'b010;
          6'h25:        alu = 3'b011;
          6'h27:        alu = 3'b100;
          6'h2A, 6'h2B: alu = 3'b101;
          6'h00:        alu = 3'b110;
          6'h02:        alu = 3'b111;
          default:      alu = 3'b000;
        endcase
      end
      6'h08, 6'h09: cls = C_INT;
      6'h0A: begin cls = C_INT; alu = 3'b101; end
      6'h0C: begin cls = C_INT; alu = 3'b010; end
      6'h0D: begin cls = C_INT; alu = 3'b011; end
      6'h04, 6'h05: begin
        cls = C_INT;
        alu = 3'b001;
        br  = 1'b1;
      end
      6'h23: cls = C_LDST;
      6'h2B: begin cls = C_LDST; alu = 3'b001; end
      6'h02, 6'h03: cls = C_JMP;
      default: cls = C_ILL;
    endcase
  end

  always_comb begin
    tgt_full = 1'b0;
    case (cls)
      C_INT:   tgt_full = dif.iq_int_full;
      C_MULT:  tgt_full = dif.iq_mult_full;
      C_LDST:  tgt_full = dif.iq_ldst_full;
      default: tgt_full = 1'b0;
    endcase
  end

  assign rob_full = cnt >= CNT_W'(ROB_DEPTH);
  assign needs    = cls inside {C_INT, C_MULT, C_LDST};
  assign blocked  = needs && (tgt_full || rob_full);
  assign com      = dif.rob_commit && (cnt != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (dif.flush)               nxt = FLUSH;
    else if (state == FLUSH)     nxt = IDLE;
    else if (!dif.ifq_valid)     nxt = IDLE;
    else if (blocked)            nxt = STALL;
    else                         nxt = DISPATCH;
  end

  // J/JAL and unsupported opcodes need no resources, so never stall
  always_comb begin
    pop = 1'b0;
    go  = 1'b0;
    if (dif.ifq_valid && !dif.flush && state != FLUSH) begin
      pop = !blocked;
      go  = !blocked && needs;
    end
  end

  assign dif.ifq_rd_en = pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag <= '0;
      cnt <= '0;
    end else if (dif.flush) begin
      tag <= '0;
      cnt <= '0;
    end else begin
      if (go)
        tag <= (tag == TAG_W'(ROB_DEPTH - 1)) ? '0
             : tag + TAG_W'(1);
      case ({go, com})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dif.Dispatch_en_integer <= 1'b0;
      dif.Dispatch_en_mult    <= 1'b0;
      dif.Dispatch_en_ld_st   <= 1'b0;
      dif.Dispatch_opcode     <= '0;
      dif.Dispatch_branch     <= 1'b0;
      dif.Dispatch_shfamt     <= '0;
      dif.Dispatch_imm_ld_st  <= '0;
      dif.Dispatch_rs         <= '0;
      dif.Dispatch_rt         <= '0;
      dif.Dispatch_rd         <= '0;
      dif.Dispatch_tag        <= '0;
      dif.Dispatch_illegal    <= 1'b0;
    end else begin
      dif.Dispatch_en_integer <= go && cls == C_INT;
      dif.Dispatch_en_mult    <= go && cls == C_MULT;
      dif.Dispatch_en_ld_st   <= go && cls == C_LDST;
      dif.Dispatch_opcode     <= go ? alu : '0;
      dif.Dispatch_branch     <= go && br;
      dif.Dispatch_shfamt     <= go ? dif.ifq_inst[10:6] : '0;
      dif.Dispatch_imm_ld_st  <= go ? dif.ifq_inst[15:0] : '0;
      dif.Dispatch_rs         <= go ? dif.ifq_inst[25:21] : '0;
      dif.Dispatch_rt         <= go ? dif.ifq_inst[20:16] : '0;
      dif.Dispatch_rd         <= go ? dif.ifq_inst[15:11] : '0;
      dif.Dispatch_tag        <= go ? tag : '0;
      dif.Dispatch_illegal    <= pop && cls == C_ILL;
    end
  end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Randomised bench for dispatch_ctrl against a mnemonic-table model
// of dispatch, tag allocation, ROB occupancy and flush.
module tb_dispatch_ctrl;
  localparam int TAG_W = 5;
  localparam int ROB_DEPTH = 32;
  localparam int K_INT = 0, K_MULT = 1, K_LDST = 2;
  localparam int K_JMP = 3, K_ILL = 4;
  localparam int NE = 27;
  localparam int I_ADD = 0, I_MULT = 11, I_LW = 20;
  localparam int I_SW = 21, I_J = 22, I_X3F = 24;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [2:0] alu;
    bit         br;
  } ent_t;

  logic clock = 1'b0;
  logic reset;
  dispatch_if #(.TAG_W(TAG_W)) dif ();

  dispatch_ctrl #(
    .TAG_W(TAG_W), .ROB_DEPTH(ROB_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .dif(dif)
  );

  always #5 clock = ~clock;

  ent_t        tbl [NE];
  int          vec = 0;
  int          errs = 0;
  int          m_tag, m_inf;
  bit          m_fl;
  int          cur_idx;
  logic [31:0] cur_inst;
  bit          popped;

  task automatic chk(input string t,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int i);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = tbl[i].op;
    if (tbl[i].op == 6'h00) w[5:0] = tbl[i].fn;
    return w;
  endfunction

  task automatic load(input int i, input logic [31:0] w);
    cur_idx  = i;
    cur_inst = w;
  endtask

  task automatic model_reset();
    m_tag = 0;
    m_inf = 0;
    m_fl  = 0;
  endtask

  task automatic step(input bit v, input bit fi, input bit fm,
                      input bit fl, input bit cm, input bit fs);
    ent_t e;
    bit   drop, busy, go;
    e = tbl[cur_idx];
    @(negedge clock);
    dif.ifq_valid    = v;
    dif.ifq_inst     = cur_inst;
    dif.iq_int_full  = fi;
    dif.iq_mult_full = fm;
    dif.iq_ldst_full = fl;
    dif.rob_commit   = cm;
    dif.flush        = fs;
    drop = e.kind >= K_JMP;
    busy = (e.kind == K_INT && fi) || (e.kind == K_MULT && fm)
        || (e.kind == K_LDST && fl) || (m_inf >= ROB_DEPTH);
    popped = v && !fs && !m_fl && (drop || !busy);
    go = popped && !drop;
    #1;
    chk("rd_en", 32'(dif.ifq_rd_en), 32'(popped));
    @(posedge clock);
    #1;
    chk("en_int", 32'(dif.Dispatch_en_integer),
        32'(go && e.kind == K_INT));
    chk("en_mult", 32'(dif.Dispatch_en_mult),
        32'(go && e.kind == K_MULT));
    chk("en_ldst", 32'(dif.Dispatch_en_ld_st),
        32'(go && e.kind == K_LDST));
    chk("illegal", 32'(dif.Dispatch_illegal),
        32'(popped && e.kind == K_ILL));
    if (go) begin
      chk("tag", 32'(dif.Dispatch_tag), 32'(m_tag));
      chk("opcode", 32'(dif.Dispatch_opcode), 32'(e.alu));
      chk("branch", 32'(dif.Dispatch_branch), 32'(e.br));
      chk("shfamt", 32'(dif.Dispatch_shfamt), 32'(cur_inst[10:6]));
      chk("imm", 32'(dif.Dispatch_imm_ld_st), 32'(cur_inst[15:0]));
      chk("rs", 32'(dif.Dispatch_rs), 32'(cur_inst[25:21]));
      chk("rt", 32'(dif.Dispatch_rt), 32'(cur_inst[20:16]));
      chk("rd", 32'(dif.Dispatch_rd), 32'(cur_inst[15:11]));
    end
    if (fs) begin
      m_tag = 0;
      m_inf = 0;
    end else begin
      if (cm && m_inf > 0) m_inf--;
      if (go) begin
        m_tag = (m_tag + 1) % ROB_DEPTH;
        m_inf++;
      end
    end
    m_fl = fs;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_en_int"}, 32'(dif.Dispatch_en_integer), 0);
    chk({t, "_en_mult"}, 32'(dif.Dispatch_en_mult), 0);
    chk({t, "_en_ldst"}, 32'(dif.Dispatch_en_ld_st), 0);
    chk({t, "_illegal"}, 32'(dif.Dispatch_illegal), 0);
    chk({t, "_tag"}, 32'(dif.Dispatch_tag), 0);
    chk({t, "_opcode"}, 32'(dif.Dispatch_opcode), 0);
  endtask

  initial begin
    tbl[0]  = '{6'h00, 6'h20, K_INT, 3'd0, 1'b0};
    tbl[1]  = '{6'h00, 6'h21, K_INT, 3'd0, 1'b0};
    tbl[2]  = '{6'h00, 6'h22, K_INT, 3'd1, 1'b0};
    tbl[3]  = '{6'h00, 6'h23, K_INT, 3'd1, 1'b0};
    tbl[4]  = '{6'h00, 6'h24, K_INT, 3'd2, 1'b0};
    tbl[5]  = '{6'h00, 6'h25, K_INT, 3'd3, 1'b0};
    tbl[6]  = '{6'h00, 6'h27, K_INT, 3'd4, 1'b0};
    tbl[7]  = '{6'h00, 6'h2A, K_INT, 3'd5, 1'b0};
    tbl[8]  = '{6'h00, 6'h2B, K_INT, 3'd5, 1'b0};
    tbl[9]  = '{6'h00, 6'h00, K_INT, 3'd6, 1'b0};
    tbl[10] = '{6'h00, 6'h02, K_INT, 3'd7, 1'b0};
    tbl[11] = '{6'h00, 6'h18, K_MULT, 3'd0, 1'b0};
    tbl[12] = '{6'h00, 6'h19, K_MULT, 3'd0, 1'b0};
    tbl[13] = '{6'h08, 6'h00, K_INT, 3'd0, 1'b0};
    tbl[14] = '{6'h09, 6'h00, K_INT, 3'd0, 1'b0};
    tbl[15] = '{6'h0A, 6'h00, K_INT, 3'd5, 1'b0};
    tbl[16] = '{6'h0C, 6'h00, K_INT, 3'd2, 1'b0};
    tbl[17] = '{6'h0D, 6'h00, K_INT, 3'd3, 1'b0};
    tbl[18] = '{6'h04, 6'h00, K_INT, 3'd1, 1'b1};
    tbl[19] = '{6'h05, 6'h00, K_INT, 3'd1, 1'b1};
    tbl[20] = '{6'h23, 6'h00, K_LDST, 3'd0, 1'b0};
    tbl[21] = '{6'h2B, 6'h00, K_LDST, 3'd1, 1'b0};
    tbl[22] = '{6'h02, 6'h00, K_JMP, 3'd0, 1'b0};
    tbl[23] = '{6'h03, 6'h00, K_JMP, 3'd0, 1'b0};
    tbl[24] = '{6'h3F, 6'h00, K_ILL, 3'd0, 1'b0};
    tbl[25] = '{6'h0B, 6'h00, K_ILL, 3'd0, 1'b0};
    tbl[26] = '{6'h0F, 6'h00, K_ILL, 3'd0, 1'b0};

    reset = 1'b0;
    dif.ifq_valid = 0; dif.ifq_inst = '0;
    dif.iq_int_full = 0; dif.iq_mult_full = 0;
    dif.iq_ldst_full = 0; dif.rob_commit = 0; dif.flush = 0;
    model_reset();
    repeat (3) @(negedge clock);
    chk_zero("rst");
    chk("rst_rd_en", 32'(dif.ifq_rd_en), 0);
    reset = 1'b1;

    load(I_ADD, 32'h012A4020);
    step(1, 0, 0, 0, 0, 0);
    load(I_MULT, 32'h01090018);
    repeat (3) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    load(I_SW, 32'hAD090004);
    step(1, 0, 0, 0, 0, 0);
    load(I_LW, 32'h8D090004);
    step(1, 0, 0, 0, 0, 0);

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    load(I_ADD, 32'h012A4020);
    repeat (33) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);

    repeat (3) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    load(I_X3F, 32'hFC000000);
    step(1, 0, 0, 0, 0, 0);
    load(I_J, 32'h08000010);
    step(1, 0, 0, 0, 0, 0);

    load(I_ADD, 32'h012A4020);
    step(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clock);
    dif.ifq_valid = 0;
    model_reset();
    reset = 1'b1;

    load($urandom_range(0, NE - 1), 32'h0);
    cur_inst = enc(cur_idx);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 4) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0);
      if (popped) begin
        cur_idx  = $urandom_range(0, NE - 1);
        cur_inst = enc(cur_idx);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
